// File: rtl/ring_slot_scheduler_if.sv
// Bus bundle for ring_slot_scheduler: slot/request/release inputs and grant/status outputs.
interface ring_slot_scheduler_if #(
    parameter int unsigned ERR_W = 8
);
    logic [3:0]       slot;
    logic [3:0]       req;
    logic [3:0]       done;
    logic [3:0]       grant;
    logic             busy;
    logic [1:0]       slot_idx;
    logic             onehot_err;
    logic             timeout;
    logic [ERR_W-1:0] err_count;

    // Upstream side: drives slot/req/done, observes grant and status.
    modport master (
        output slot, req, done,
        input  grant, busy, slot_idx, onehot_err, timeout, err_count
    );

    // Scheduler side.
    modport slave (
        input  slot, req, done,
        output grant, busy, slot_idx, onehot_err, timeout, err_count
    );
endinterface

// File: rtl/ring_slot_scheduler.sv
// Time-slot driven single-owner arbiter with hold timeout and one-hot slot checking.
module ring_slot_scheduler #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ring_slot_scheduler_if.slave  bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int unsigned      HOLD_W   = 8;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [1:0]        idx_q;
    logic              oerr_q;
    logic [ERR_W-1:0]  err_q;

    logic              slot_valid;
    logic [1:0]        slot_bin;

    // Decode the slot vector: valid only when exactly one bit is set.
    always_comb begin
        slot_valid = 1'b0;
        slot_bin   = 2'd0;
        case (bus.slot)
            4'b0001: begin slot_valid = 1'b1; slot_bin = 2'd0; end
            4'b0010: begin slot_valid = 1'b1; slot_bin = 2'd1; end
            4'b0100: begin slot_valid = 1'b1; slot_bin = 2'd2; end
            4'b1000: begin slot_valid = 1'b1; slot_bin = 2'd3; end
            default: begin slot_valid = 1'b0; slot_bin = 2'd0; end
        endcase
    end

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        grant_d   = 4'b0000;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slot_valid && bus.req[slot_bin]) begin
                    state_d = ST_ACTIVE;
                    owner_d = slot_bin;
                    hold_d  = HOLD_W'(1);
                    grant_d = 4'b0001 << slot_bin;
                end
            end
            ST_ACTIVE: begin
                // Owner release wins over timeout in the last permitted cycle.
                if (bus.done[owner_q]) begin
                    state_d = ST_RELEASE;
                end else if (hold_q == HOLD_MAX) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                    grant_d = grant_q;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state and registered grant/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 2'd0;
            hold_q    <= '0;
            grant_q   <= 4'b0000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Slot checking runs in every FSM state; the error counter saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= 2'd0;
            oerr_q <= 1'b0;
            err_q  <= '0;
        end else begin
            oerr_q <= ~slot_valid;
            if (slot_valid) begin
                idx_q <= slot_bin;
            end else if (err_q != {ERR_W{1'b1}}) begin
                err_q <= err_q + ERR_W'(1);
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.slot_idx   = idx_q;
    assign bus.onehot_err = oerr_q;
    assign bus.timeout    = timeout_q;
    assign bus.err_count  = err_q;

endmodule

// File: tb/tb_ring_slot_scheduler.sv
// Self-checking bench for ring_slot_scheduler using a cycle model feeding a scoreboard queue.
module tb_ring_slot_scheduler;
    localparam int MAX_HOLD = 8;
    localparam int ERR_W    = 8;

    typedef struct packed {
        logic [3:0] grant;
        logic       busy;
        logic [1:0] idx;
        logic       oerr;
        logic       tmo;
        logic [7:0] errc;
    } obs_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    obs_t sb[$];

    ring_slot_scheduler_if #(.ERR_W(ERR_W)) bus ();

    ring_slot_scheduler #(.MAX_HOLD(MAX_HOLD), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    int         m_state;   // 0 idle, 1 active, 2 release
    int         m_owner;
    int         m_hold;
    logic [3:0] m_grant;
    logic [1:0] m_idx;
    logic       m_oerr;
    logic       m_tmo;
    int         m_err;

    task automatic model_reset();
        m_state = 0; m_owner = 0; m_hold = 0; m_grant = 4'b0000;
        m_idx = 2'd0; m_oerr = 1'b0; m_tmo = 1'b0; m_err = 0;
    endtask

    task automatic model_step(input logic [3:0] s, input logic [3:0] r,
                              input logic [3:0] d, output obs_t e);
        int ones;
        int pos;
        ones = 0;
        pos  = 0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                ones++;
                pos = i;
            end
        end
        m_oerr = (ones != 1);
        if (ones == 1) m_idx = 2'(pos);
        else if (m_err < 255) m_err++;
        m_tmo = 1'b0;
        if (m_state == 0) begin
            m_grant = 4'b0000;
            if (ones == 1 && r[pos]) begin
                m_state = 1; m_owner = pos; m_hold = 1;
                m_grant = 4'b0000;
                m_grant[pos] = 1'b1;
            end
        end else if (m_state == 1) begin
            if (d[m_owner]) begin
                m_state = 2; m_grant = 4'b0000;
            end else if (m_hold >= MAX_HOLD) begin
                m_state = 2; m_grant = 4'b0000; m_tmo = 1'b1;
            end else begin
                m_hold++;
            end
        end else begin
            m_state = 0; m_grant = 4'b0000;
        end
        e.grant = m_grant;
        e.busy  = (m_state != 0);
        e.idx   = m_idx;
        e.oerr  = m_oerr;
        e.tmo   = m_tmo;
        e.errc  = 8'(m_err);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.grant = bus.grant;
        o.busy  = bus.busy;
        o.idx   = bus.slot_idx;
        o.oerr  = bus.onehot_err;
        o.tmo   = bus.timeout;
        o.errc  = bus.err_count;
        return o;
    endfunction

    // Drive one cycle of stimulus, push the model's expectation, sample after the edge.
    task automatic drive_cycle(input logic [3:0] s, input logic [3:0] r, input logic [3:0] d);
        obs_t e;
        bus.slot = s;
        bus.req  = r;
        bus.done = d;
        model_step(s, r, d, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.slot = 4'b0000; bus.req = 4'b0000; bus.done = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b1;
        bus.slot = 4'b0001; bus.req = 4'b1111; bus.done = 4'b0000;
        #2;
        repeat (2) @(posedge clk);
        #1;
        got = sample();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, obs_t'(0));
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_grant();
        logic [3:0] st [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] rq [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] dn [4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
        obs_t got, exp;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(st[i], rq[i], dn[i]);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_grant[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] st [6] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
        logic [3:0] rq [6] = '{4'b0100, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
        logic [3:0] dn [6] = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        obs_t got, exp;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(st[i], rq[i], dn[i]);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL release[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t got, exp;
        int   held;
        int   tmos;
        for (int pass = 0; pass < 2; pass++) begin
            held = 0;
            tmos = 0;
            for (int i = 0; i < 12; i++) begin
                logic [3:0] s;
                logic [3:0] d;
                s = (i == 0) ? 4'b1000 : 4'b0001 << (i % 4);
                d = (pass == 1 && i == 8) ? 4'b1000 : 4'b0000;
                drive_cycle(s, (i == 0) ? 4'b1000 : 4'b0000, d);
                exp = sb.pop_front();
                got = sample();
                if (got.grant != 4'b0000) held++;
                if (got.tmo) tmos++;
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL timeout_p%0d[%0d]: got %h expected %h", pass, i, got, exp);
                end
            end
            checks++;
            if (held != MAX_HOLD) begin
                errors++;
                $display("FAIL hold_cycles_p%0d: got %0d expected %0d", pass, held, MAX_HOLD);
            end
            checks++;
            if (tmos != ((pass == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL timeout_pulses_p%0d: got %0d expected %0d", pass, tmos, (pass == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_illegal_slot();
        logic [3:0] st [3] = '{4'b0010, 4'b0110, 4'b0000};
        logic [3:0] rq [3] = '{4'b0000, 4'b1111, 4'b1111};
        obs_t got, exp;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(st[i], rq[i], 4'b0000);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL illegal_slot[%0d]: got %h expected %h", i, got, exp);
            end
        end
        checks++;
        if (bus.err_count !== 8'd2 || bus.slot_idx !== 2'd1 || bus.grant !== 4'b0000) begin
            errors++;
            $display("FAIL illegal_summary: got err=%0d idx=%0d grant=%b expected err=2 idx=1 grant=0000",
                     bus.err_count, bus.slot_idx, bus.grant);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] pat [3] = '{4'b0000, 4'b1111, 4'b0011};
        obs_t got, exp;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            drive_cycle(pat[i % 3], 4'b1111, 4'b0000);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL saturation[%0d]: got %h expected %h", i, got, exp);
            end
        end
        checks++;
        if (bus.err_count !== 8'd255) begin
            errors++;
            $display("FAIL err_saturated: got %0d expected 255", bus.err_count);
        end
    endtask

    task automatic test_async_reset();
        obs_t got, exp;
        drive_cycle(4'b0010, 4'b0000, 4'b0000);
        void'(sb.pop_front());
        drive_cycle(4'b0000, 4'b0000, 4'b0000);
        void'(sb.pop_front());
        drive_cycle(4'b0100, 4'b0100, 4'b0000);
        exp = sb.pop_front();
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_pre: got %h expected %h", got, exp);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.err_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got grant=%b busy=%b err=%0d expected 0000/0/0",
                     bus.grant, bus.busy, bus.err_count);
        end
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            drive_cycle((i == 0) ? 4'b0001 : 4'b0010, (i == 0) ? 4'b0001 : 4'b0000, 4'b0000);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_post[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        logic [3:0] s;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 15));
            else s = 4'b0001 << $urandom_range(0, 3);
            drive_cycle(s, 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
            exp = sb.pop_front();
            got = sample();
            checks++;
            if (got !== exp || $countones(got.grant) > 1) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.slot = 4'b0000; bus.req = 4'b0000; bus.done = 4'b0000;
        model_reset();
        test_reset();
        test_basic_grant();
        test_release();
        test_timeout();
        test_illegal_slot();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
